// File: rtl/cpu_mem_pkg.sv
// Shared widths, state encoding and mode constants for the block mover.
package cpu_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/mem_block_mover.sv
// Block copy / fill engine mastering the write port of a 256x16 single-port memory.
// state | meaning: IDLE wait for start; READ latch source word; WRITE store one word; DONE one-cycle done pulse
module mem_block_mover
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] din_hold_q, din_hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COPY;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      words_q     <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      words_q     <= words_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
    data_d      = data_q;
    words_d     = words_q;
    mem_enable  = 1'b0;
    mem_address = addr_hold_q;
    mem_data_in = din_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          fill_d  = fill_value;
          words_d = '0;
          if (length == '0)            state_d = ST_DONE;
          else if (mode == MODE_FILL)  state_d = ST_WRITE;
          else                         state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_address = src_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = mem_data_out;
          src_d   = src_q + ADDR_W'(1);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_address = dst_q;
        mem_data_in = (mode_q == MODE_FILL) ? fill_q : data_q;
        // Abort must suppress the write in the same cycle, not the next.
        mem_enable  = !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          dst_d   = dst_q + ADDR_W'(1);
          words_d = words_q + LEN_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))       state_d = ST_DONE;
          else if (mode_q == MODE_FILL) state_d = ST_WRITE;
          else                          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    addr_hold_d = mem_address;
    din_hold_d  = mem_data_in;
  end

  assign busy       = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign words_done = words_q;

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus-master engine that drives the single-port 256x16 memory's write port: enable, address and data_in. It reads the memory's combinational data_out.
- Two modes: copy a block of words from a source region to a destination region, or fill a region with a constant.
- Sits beside the CPU datapath and offloads block moves and clears. While busy it owns the memory port; the CPU must not drive the port.

Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory word width
- LEN_W, 9, length field width (0..256 words)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; captured with start
- src_addr  input  ADDR_W  copy source base; captured with start
- dst_addr  input  ADDR_W  destination base; captured with start
- length  input  LEN_W  number of words; captured with start
- fill_value  input  DATA_W  fill word; captured with start
- abort  input  1  synchronous cancel
- busy  output  1  high in READ or WRITE
- done  output  1  one-cycle pulse on normal completion
- words_done  output  LEN_W  words written so far in the current or last job
- mem_enable  output  1  memory write enable
- mem_address  output  ADDR_W  memory address
- mem_data_in  output  DATA_W  write data to memory
- mem_data_out  input  DATA_W  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, busy=0, done=0, words_done=0, mem_enable=0, mem_address=0, mem_data_in=0, all captured registers 0.
- Reset mid-job: mem_enable drops immediately (asynchronously) and no further writes occur.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 at an edge captures mode, src_addr, dst_addr, length and fill_value, and clears words_done.
  - length=0 -> DONE.
  - mode=0 -> READ.
  - mode=1 -> WRITE.
- READ (copy only):
  - mem_address=src_ptr, mem_enable=0.
  - At the edge, latch mem_data_out into a data register, increment src_ptr, go to WRITE.
- WRITE:
  - mem_address=dst_ptr, mem_data_in = latched data (copy) or fill_value (fill), mem_enable=1.
  - At the edge: increment dst_ptr and words_done, decrement remaining.
  - If remaining was 1 -> DONE; else copy -> READ, fill -> WRITE.
- DONE: done=1, busy=0, mem_enable=0, then -> IDLE. done is high for exactly one cycle.
- Latency, counting start-edge = edge 0:
  - Copy of N words: done high in the cycle after edge 2N.
  - Fill of N words: done high in the cycle after edge N.
  - length=0: done high in the cycle after edge 0, with no memory write.
- Pointer arithmetic: src_ptr and dst_ptr are ADDR_W-bit and wrap modulo 256 (255+1 = 0). length=256 touches every address exactly once.
- Overlap: copy is strictly ascending, read-before-write per word.
  - dst > src with overlapping regions propagates already-written data. This is the defined result and is not corrected.
- abort:
  - Ignored in IDLE and DONE.
  - In READ or WRITE, mem_enable is forced to 0 combinationally in that cycle, so no write happens.
  - Next state is IDLE, done is not pulsed, and words_done holds its count.
- Simultaneous events:
  - reset dominates all.
  - abort dominates state advance.
  - start while busy or in DONE is ignored (not queued).
- mem_address in IDLE and DONE holds its last driven value. Only mem_enable qualifies a write.
- words_done is stable in IDLE until the next accepted start.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - ADDR_W, DATA_W, LEN_W
  - the state encoding localparams ST_IDLE, ST_READ, ST_WRITE, ST_DONE
  - the mode constants MODE_COPY, MODE_FILL
- No sub-module is needed: one FSM plus pointer and counter registers.
- The bench instantiates the existing 256x16 memory model as the slave.

Test Plan:
- Copy, no wrap: preload mem[0x10..0x13]=A1,B2,C3,D4. start, copy, src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=A1,B2,C3,D4; exactly 4 enable pulses; done in the cycle after edge 8; words_done=4.
- Fill with wrap: start, fill, dst=0xFE, len=4, fill_value=0xBEEF -> mem[0xFE], mem[0xFF], mem[0x00], mem[0x01]=0xBEEF; mem[0x02] unchanged; done in the cycle after edge 4.
- Zero length: start with len=0 -> no mem_enable ever high; done in the cycle after edge 0; busy never 1.
- Overlap: mem[0..2]=1,2,3. Copy src=0, dst=1, len=2 -> mem[1]=1, mem[2]=1.
- Abort: fill len=10, abort asserted in the 3rd WRITE cycle -> only 2 words written; mem_enable low during the abort cycle; no done pulse; words_done=2; next start is accepted.
- Async reset mid-copy: reset raised between clock edges during WRITE -> mem_enable drops to 0 before the next edge; all outputs at reset values; start after reset release works normally.
